// File: rtl/dht11_pkg.sv
// DHT11 shared definitions: FSM states, frame size, default protocol timing.
// Timing defaults are in microseconds and shared with the host controller.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        HOST_REL,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        EOT_LOW
    } state_t;

    localparam int FRAME_BITS      = 40;

    localparam int DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int DEF_START_MIN   = 1000;
    localparam int DEF_RESP_WAIT   = 30;
    localparam int DEF_RESP_LOW    = 80;
    localparam int DEF_RESP_HIGH   = 80;
    localparam int DEF_BIT_LOW     = 50;
    localparam int DEF_BIT0_HIGH   = 26;
    localparam int DEF_BIT1_HIGH   = 70;
    localparam int DEF_EOT_LOW     = 50;

    // 8-bit truncated sum of the four payload bytes
    function automatic logic [7:0] cksum8(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic [7:0] d
    );
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// DHT11 microsecond prescaler: one-cycle us_tick every CLK_PER_US clocks,
// phase restarted whenever restart is high.
module dht11_us_tick #(
    parameter int CLK_PER_US = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic us_tick
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt;

    assign us_tick = (cnt == LAST);

    // cycle counter, cleared on restart and on every completed microsecond
    always_ff @(posedge clk) begin
        if (reset || restart || us_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: qualifies host start, sends preamble + 40-bit frame.
// Optional macro DHT11_CKSUM_ERR_INJ_EN adds cksum_corrupt (flips checksum LSB).
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int START_MIN_US = DEF_START_MIN,
    parameter int RESP_WAIT_US = DEF_RESP_WAIT,
    parameter int RESP_LOW_US  = DEF_RESP_LOW,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH,
    parameter int BIT_LOW_US   = DEF_BIT_LOW,
    parameter int BIT0_HIGH_US = DEF_BIT0_HIGH,
    parameter int BIT1_HIGH_US = DEF_BIT1_HIGH,
    parameter int EOT_LOW_US   = DEF_EOT_LOW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dht_in,
    output logic       dht_drive_low,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
`ifdef DHT11_CKSUM_ERR_INJ_EN
    input  logic       cksum_corrupt,
`endif
    output logic       busy,
    output logic       frame_done
);

    localparam int CLK_PER_US = CLK_FREQ_HZ / 1_000_000;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  sync;
    logic        line_s;
    logic [15:0] us_cnt;
    logic [15:0] dur;
    logic [5:0]  bit_idx;
    logic [39:0] shreg;
    logic [7:0]  cksum;
    logic        us_tick;
    logic        restart;
    logic        timeout;
    logic        snap;
    logic        start_ok;
    logic        drive_nx;
    logic        busy_nx;
    logic        done_nx;

    assign line_s   = sync[1];
    assign restart  = (state_nx != state);
    assign timeout  = us_tick && (us_cnt == dur - 16'd1);
    assign start_ok = (us_cnt >= 16'(START_MIN_US));

`ifdef DHT11_CKSUM_ERR_INJ_EN
    assign cksum = cksum8(hum_int, hum_dec, tmp_int, tmp_dec)
                 ^ {7'd0, cksum_corrupt};
`else
    assign cksum = cksum8(hum_int, hum_dec, tmp_int, tmp_dec);
`endif

    dht11_us_tick #(
        .CLK_PER_US(CLK_PER_US)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .us_tick(us_tick)
    );

    // duration of the current timed state in microseconds
    always_comb begin
        dur = 16'd0;
        unique case (state)
            HOST_REL:  dur = 16'(RESP_WAIT_US);
            RESP_LOW:  dur = 16'(RESP_LOW_US);
            RESP_HIGH: dur = 16'(RESP_HIGH_US);
            BIT_LOW:   dur = 16'(BIT_LOW_US);
            BIT_HIGH:  dur = shreg[39] ? 16'(BIT1_HIGH_US)
                                       : 16'(BIT0_HIGH_US);
            EOT_LOW:   dur = 16'(EOT_LOW_US);
            default:   dur = 16'd0;
        endcase
    end

    // next state, snapshot strobe and registered-output next values
    always_comb begin
        state_nx = state;
        snap     = 1'b0;
        unique case (state)
            IDLE:      if (enable && !line_s) state_nx = HOST_LOW;
            HOST_LOW:  if (line_s) begin
                           if (start_ok) begin
                               state_nx = HOST_REL;
                               snap     = 1'b1;
                           end else begin
                               state_nx = IDLE;
                           end
                       end
            HOST_REL:  if (timeout) state_nx = RESP_LOW;
            RESP_LOW:  if (timeout) state_nx = RESP_HIGH;
            RESP_HIGH: if (timeout) state_nx = BIT_LOW;
            BIT_LOW:   if (timeout) state_nx = BIT_HIGH;
            BIT_HIGH:  if (timeout) begin
                           if (bit_idx == 6'(FRAME_BITS - 1)) state_nx = EOT_LOW;
                           else state_nx = BIT_LOW;
                       end
            EOT_LOW:   if (timeout) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        drive_nx = (state_nx == RESP_LOW) || (state_nx == BIT_LOW)
                || (state_nx == EOT_LOW);
        done_nx  = (state == EOT_LOW) && (state_nx == IDLE);
        busy_nx  = done_nx
                || ((state_nx != IDLE) && (state_nx != HOST_LOW));
    end

    // state register, line synchronizer and glitch-free registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sync          <= 2'b11;
            dht_drive_low <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            sync          <= {sync[0], dht_in};
            dht_drive_low <= drive_nx;
            busy          <= busy_nx;
            frame_done    <= done_nx;
        end
    end

    // microsecond counter, bit index and frame shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            us_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (restart) begin
                us_cnt <= '0;
            end else if (us_tick && state != IDLE
                         && !(state == HOST_LOW && start_ok)) begin
                us_cnt <= us_cnt + 16'd1;
            end
            if (snap) begin
                shreg <= {hum_int, hum_dec, tmp_int, tmp_dec, cksum};
            end else if (state == BIT_HIGH && timeout) begin
                shreg <= {shreg[38:0], 1'b0};
            end
            if (state == RESP_HIGH && timeout) begin
                bit_idx <= '0;
            end else if (state == BIT_HIGH && timeout) begin
                bit_idx <= bit_idx + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder: random/directed frames, line-level
// scoreboard decoding the responder waveform against a byte-level model.
module tb_dht11_responder;

    localparam int K     = 2;
    localparam int HL_US = 1100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] hi = '0, hd = '0, ti = '0, td = '0;
    logic       dht_in;
    logic       drive;
    logic       busy;
    logic       done;
`ifdef DHT11_CKSUM_ERR_INJ_EN
    logic       cc = 1'b0;
`endif

    // wired-AND open-drain line with pull-up
    assign dht_in = !(host_low || drive);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dht11_responder #(
        .CLK_FREQ_HZ(K * 1_000_000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dht_in       (dht_in),
        .dht_drive_low(drive),
        .enable       (enable),
        .hum_int      (hi),
        .hum_dec      (hd),
        .tmp_int      (ti),
        .tmp_dec      (td),
`ifdef DHT11_CKSUM_ERR_INJ_EN
        .cksum_corrupt(cc),
`endif
        .busy         (busy),
        .frame_done   (done)
    );

    int n_chk = 0;
    int n_pass = 0;
    int exp_done = 0;
    int n_done = 0;

    typedef struct {
        logic [39:0] data;
        int          rel;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // reference: payload bytes then the mod-256 sum, optionally LSB-flipped
    function automatic logic [39:0] model_frame(
        input logic [7:0] a, input logic [7:0] b,
        input logic [7:0] c, input logic [7:0] d, input bit corr
    );
        int s;
        int ck;
        s  = a + b + c + d;
        ck = s % 256;
        if (corr) ck = ck ^ 1;
        return {a, b, c, d, 8'(ck)};
    endfunction

    // monitor: splits dht_drive_low into segments and checks each frame
    initial begin : monitor
        bit          prev;
        bit          in_frame;
        bit          want_idle;
        bit          b;
        int          run;
        int          seg;
        int          bad;
        logic [39:0] got;
        exp_t        cur;
        prev = 0; in_frame = 0; want_idle = 0;
        run = 0; seg = 0; bad = 0; got = '0;
        cur = '{40'd0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 0; in_frame = 0; want_idle = 0; run = 0;
                continue;
            end
            if (want_idle) begin
                check("busy_after_done", busy, 0);
                want_idle = 0;
            end
            if (done) n_done++;
            if (drive == prev) begin
                run++;
            end else begin
                if (in_frame) begin
                    if (seg == 0) begin
                        check("resp_low_len", run, 80 * K);
                    end else if (seg == 1) begin
                        check("resp_high_len", run, 80 * K);
                    end else if (seg < 82) begin
                        if (seg % 2 == 0) begin
                            if (run != 50 * K) bad++;
                        end else begin
                            b   = cur.data[39 - (seg - 3) / 2];
                            got = {got[38:0], run > 48 * K};
                            if (run != (b ? 70 : 26) * K) bad++;
                        end
                    end else begin
                        check("eot_low_len", run, 50 * K);
                        check("bit_timing_errs", bad, 0);
                        check("frame_data", got, cur.data);
                        check("frame_done_at_release", done, 1);
                        want_idle = 1;
                        in_frame  = 0;
                    end
                    seg++;
                end else if (drive) begin
                    check("resp_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        check("resp_wait_len", cyc - cur.rel, 30 * K + 3);
                        check("busy_in_frame", busy, 1);
                        in_frame = 1; seg = 0; bad = 0; got = '0;
                    end
                end
                prev = drive;
                run  = 1;
            end
        end
    end

    task automatic set_vals(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input bit corr);
        hi = a; hd = b; ti = c; td = d;
`ifdef DHT11_CKSUM_ERR_INJ_EN
        cc = corr;
`else
        if (corr) $display("note: checksum corruption not built in");
`endif
    endtask

    task automatic wait_done(input bit mutate);
        int t;
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
            if (mutate && t == 3000) begin
                hi = 8'($urandom); hd = 8'($urandom);
                ti = 8'($urandom); td = 8'($urandom);
            end
        end
        check("frame_timeout", t < 20000, 1);
        repeat (20) @(negedge clk);
    endtask

    // host start (optionally with enable raised late), then a full frame
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input bit corr, input bit mutate, input int pre_us);
        set_vals(a, b, c, d, corr);
        host_low = 1;
        if (pre_us > 0) begin
            enable = 0;
            repeat (pre_us * K) @(negedge clk);
            enable = 1;
        end
        repeat (HL_US * K) @(negedge clk);
        host_low = 0;
        sb.push_back('{model_frame(a, b, c, d, corr), cyc});
        exp_done++;
        wait_done(mutate);
    endtask

    // host low that must not produce any response
    task automatic host_quiet(input int pre_us, input int low_us,
                              input bit en, input string name);
        int act;
        act = 0;
        host_low = 1;
        enable = en;
        repeat (pre_us * K) begin @(negedge clk); act += int'(busy || drive); end
        enable = 1;
        repeat (low_us * K) begin @(negedge clk); act += int'(busy || drive); end
        host_low = 0;
        repeat (400 * K) begin @(negedge clk); act += int'(busy || drive); end
        check(name, act, 0);
    endtask

    task automatic abort_frame();
        int  r;
        int  t;
        bit  p;
        set_vals(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
        host_low = 1;
        repeat (HL_US * K) @(negedge clk);
        host_low = 0;
        sb.push_back('{model_frame(hi, hd, ti, td, 0), cyc});
        r = 0; t = 0; p = 0;
        while (r < 5 && t < 20000) begin
            @(negedge clk);
            t++;
            if (drive && !p) r++;
            p = drive;
        end
        check("abort_reach_bit_low", r, 5);
        reset = 1;
        @(posedge clk);
        #1;
        check("abort_drive", drive, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_drive", drive, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 0;
        enable = 1;
        repeat (10) @(negedge clk);

        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 0, 0);
        host_quiet(0, 500, 1, "short_start_quiet");
        run_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 0, 1, 0);
        abort_frame();
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 0);
        host_quiet(HL_US, 0, 0, "disabled_quiet");
        host_quiet(600, 600, 0, "late_enable_short_quiet");
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 300);
`ifdef DHT11_CKSUM_ERR_INJ_EN
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1, 0, 0);
        cc = 0;
`endif

        repeat (50) @(negedge clk);
        check("frame_done_count", n_done, exp_done);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
